// File: rtl/signal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signal_pkg
// Purpose  : Shared constants, rate table and FSM state type for the SIGNAL
//            field parser (RATE codes, N_DBPS values, field bit counts).
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package signal_pkg;

  localparam int SIG_BITS     = 24;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  // RATE codes as received (bit 0 = first received bit R1)
  localparam logic [3:0] RATE_6  = 4'hB;
  localparam logic [3:0] RATE_9  = 4'hF;
  localparam logic [3:0] RATE_12 = 4'hA;
  localparam logic [3:0] RATE_18 = 4'hE;
  localparam logic [3:0] RATE_24 = 4'h9;
  localparam logic [3:0] RATE_36 = 4'hD;
  localparam logic [3:0] RATE_48 = 4'h8;
  localparam logic [3:0] RATE_54 = 4'hC;

  localparam logic [7:0] NDBPS_6  = 8'd24;
  localparam logic [7:0] NDBPS_9  = 8'd36;
  localparam logic [7:0] NDBPS_12 = 8'd48;
  localparam logic [7:0] NDBPS_18 = 8'd72;
  localparam logic [7:0] NDBPS_24 = 8'd96;
  localparam logic [7:0] NDBPS_36 = 8'd144;
  localparam logic [7:0] NDBPS_48 = 8'd192;
  localparam logic [7:0] NDBPS_54 = 8'd216;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_DIV     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Zero marks an illegal RATE code.
  function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
    case (rate)
      RATE_6:  return NDBPS_6;
      RATE_9:  return NDBPS_9;
      RATE_12: return NDBPS_12;
      RATE_18: return NDBPS_18;
      RATE_24: return NDBPS_24;
      RATE_36: return NDBPS_36;
      RATE_48: return NDBPS_48;
      RATE_54: return NDBPS_54;
      default: return 8'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sig_divider.sv
`default_nettype none
// ============================================================================
// Module   : sig_divider
// Purpose  : 16-bit / 8-bit restoring divider, one quotient bit per cycle,
//            fixed 16-cycle latency after i_start.
// Ports    : i_clk, i_rst_n     clock, async active-low reset
//            i_start            load operands and begin (1-cycle pulse)
//            i_num[15:0]        numerator
//            i_den[7:0]         divisor (nonzero)
//            o_quot[15:0]       quotient (valid after the o_last cycle)
//            o_rem[7:0]         remainder (valid after the o_last cycle)
//            o_last             high during the final iteration cycle
// Revision : 1.0 - initial release
// ============================================================================
module sig_divider (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_num,
  input  logic [7:0]  i_den,
  output logic [15:0] o_quot,
  output logic [7:0]  o_rem,
  output logic        o_last
);

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [15:0] r_q;     // numerator shifts out the top, quotient shifts in
  logic [7:0]  r_rem;
  logic [7:0]  r_den;

  logic [8:0]  w_trial;
  logic [8:0]  w_diff;
  logic        w_ge;

  // Remainder is always below the divisor (< 256), so the trial fits 9 bits.
  assign w_trial = {r_rem, r_q[15]};
  assign w_diff  = w_trial - {1'b0, r_den};
  assign w_ge    = (w_trial >= {1'b0, r_den});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
      r_q    <= 16'd0;
      r_rem  <= 8'd0;
      r_den  <= 8'd0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= 4'd0;
      r_q    <= i_num;
      r_rem  <= 8'd0;
      r_den  <= i_den;
    end else if (r_busy) begin
      r_q   <= {r_q[14:0], w_ge};
      r_rem <= 8'(w_ge ? w_diff : w_trial);
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_quot = r_q;
  assign o_rem  = r_rem;
  assign o_last = r_busy && (r_cnt == 4'd15);

endmodule
`default_nettype wire

// File: rtl/signal_field_parser.sv
`default_nettype none
// ============================================================================
// Module   : signal_field_parser
// Purpose  : Collects the 24 decoded SIGNAL bits of an OFDM frame, checks
//            RATE / reserved / parity / tail, derives N_DBPS and computes
//            N_SYM = ceil((22 + 8*LEN) / N_DBPS). Results hold until the
//            next frame_start.
// Ports    : clk_In, rst_n_In   clock, async active-low reset
//            frame_start        restart collection (any state)
//            din, din_vld       decoded SIGNAL bit stream, R1 first
//            busy               frame in progress
//            sig_done           1-cycle pulse, results valid from here
//            sig_ok             no error flag set
//            sig_rate/len       captured RATE and LENGTH fields
//            sig_ndbps/nsym     data bits per symbol, symbol count
//            err_rate/parity/tail/rsvd  individual check results
// Revision : 1.0 - initial release
// ============================================================================
module signal_field_parser #(
  parameter int SIG_BITS = 24,
  parameter int LEN_W    = 12,
  parameter int NSYM_W   = 12
) (
  input  logic              clk_In,
  input  logic              rst_n_In,
  input  logic              frame_start,
  input  logic              din,
  input  logic              din_vld,
  output logic              busy,
  output logic              sig_done,
  output logic              sig_ok,
  output logic [3:0]        sig_rate,
  output logic [LEN_W-1:0]  sig_len,
  output logic [7:0]        sig_ndbps,
  output logic [NSYM_W-1:0] sig_nsym,
  output logic              err_rate,
  output logic              err_parity,
  output logic              err_tail,
  output logic              err_rsvd
);

  import signal_pkg::*;

  state_t              r_state;
  state_t              w_next;
  logic [SIG_BITS-1:0] r_bits;
  logic [4:0]          r_cnt;

  logic                r_sig_done;
  logic                r_sig_ok;
  logic [3:0]          r_sig_rate;
  logic [LEN_W-1:0]    r_sig_len;
  logic [7:0]          r_sig_ndbps;
  logic [NSYM_W-1:0]   r_sig_nsym;
  logic                r_err_rate;
  logic                r_err_parity;
  logic                r_err_tail;
  logic                r_err_rsvd;

  logic [3:0]          w_rate;
  logic [LEN_W-1:0]    w_len;
  logic [7:0]          w_ndbps;
  logic                w_err_rate;
  logic                w_err_parity;
  logic                w_err_tail;
  logic                w_err_rsvd;
  logic                w_any_err;
  logic [15:0]         w_num;
  logic                w_div_start;
  logic                w_div_last;
  logic [15:0]         w_quot;
  logic [7:0]          w_rem;

  // Field decode works straight off the capture register; it is stable
  // from CHECK through DONE because no capture happens outside COLLECT.
  assign w_rate       = r_bits[3:0];
  assign w_len        = r_bits[5 +: LEN_W];
  assign w_ndbps      = rate_to_ndbps(w_rate);
  assign w_err_rate   = (w_ndbps == 8'd0);
  assign w_err_parity = ^r_bits[17:0];
  assign w_err_tail   = |r_bits[SIG_BITS-1:18];
  assign w_err_rsvd   = r_bits[4];
  assign w_any_err    = w_err_rate | w_err_parity | w_err_tail | w_err_rsvd;

  // Service + tail bits plus 8 bits per LENGTH octet; max 32782 fits 16 bits.
  assign w_num       = 16'(SERVICE_BITS + TAIL_BITS) + (16'(w_len) << 3);
  assign w_div_start = (r_state == S_CHECK) && !w_any_err;

  sig_divider u_div (
    .i_clk   (clk_In),
    .i_rst_n (rst_n_In),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_ndbps),
    .o_quot  (w_quot),
    .o_rem   (w_rem),
    .o_last  (w_div_last)
  );

  always_ff @(posedge clk_In or negedge rst_n_In) begin
    if (!rst_n_In) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (frame_start) begin
      w_next = S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_IDLE;
        S_COLLECT: if (din_vld && (r_cnt == 5'(SIG_BITS - 1))) w_next = S_CHECK;
        S_CHECK:   w_next = w_any_err ? S_DONE : S_DIV;
        S_DIV:     if (w_div_last) w_next = S_DONE;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Results register on the edge that leaves DONE, so sig_done appears
  // together with busy dropping and the results it qualifies.
  always_ff @(posedge clk_In or negedge rst_n_In) begin
    if (!rst_n_In) begin
      r_bits       <= '0;
      r_cnt        <= 5'd0;
      r_sig_done   <= 1'b0;
      r_sig_ok     <= 1'b0;
      r_sig_rate   <= 4'd0;
      r_sig_len    <= '0;
      r_sig_ndbps  <= 8'd0;
      r_sig_nsym   <= '0;
      r_err_rate   <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_tail   <= 1'b0;
      r_err_rsvd   <= 1'b0;
    end else begin
      r_sig_done <= 1'b0;
      if (frame_start) begin
        // A bit qualified in the frame_start cycle is bit 0 of the new frame.
        r_bits       <= {{(SIG_BITS-1){1'b0}}, din_vld & din};
        r_cnt        <= din_vld ? 5'd1 : 5'd0;
        r_sig_ok     <= 1'b0;
        r_sig_rate   <= 4'd0;
        r_sig_len    <= '0;
        r_sig_ndbps  <= 8'd0;
        r_sig_nsym   <= '0;
        r_err_rate   <= 1'b0;
        r_err_parity <= 1'b0;
        r_err_tail   <= 1'b0;
        r_err_rsvd   <= 1'b0;
      end else if ((r_state == S_COLLECT) && din_vld) begin
        r_bits[r_cnt] <= din;
        r_cnt         <= r_cnt + 5'd1;
      end else if (r_state == S_DONE) begin
        r_sig_done   <= 1'b1;
        r_sig_ok     <= !w_any_err;
        r_sig_rate   <= w_rate;
        r_sig_len    <= w_len;
        r_sig_ndbps  <= w_ndbps;
        r_sig_nsym   <= w_any_err ? '0 : NSYM_W'(w_quot + {15'd0, (w_rem != 8'd0)});
        r_err_rate   <= w_err_rate;
        r_err_parity <= w_err_parity;
        r_err_tail   <= w_err_tail;
        r_err_rsvd   <= w_err_rsvd;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign sig_done   = r_sig_done;
  assign sig_ok     = r_sig_ok;
  assign sig_rate   = r_sig_rate;
  assign sig_len    = r_sig_len;
  assign sig_ndbps  = r_sig_ndbps;
  assign sig_nsym   = r_sig_nsym;
  assign err_rate   = r_err_rate;
  assign err_parity = r_err_parity;
  assign err_tail   = r_err_tail;
  assign err_rsvd   = r_err_rsvd;

endmodule
`default_nettype wire
